// File: rtl/uart_tx_queue_pkg.sv
// Shared types and defaults for the UART transmit queue: launch FSM states
// and the default acknowledge timeout.
package uart_tx_queue_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LAUNCH    = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } txq_state_e;

   localparam int TXQ_DEPTH_DEFAULT       = 16;
   localparam int TXQ_ADDR_W_DEFAULT      = 4;
   localparam int TXQ_ACK_TIMEOUT_DEFAULT = 255;
   localparam int TXQ_DATA_W              = 8;

endpackage

// File: rtl/uart_tx_queue_sync_fifo.sv
// Synchronous byte FIFO with registered occupancy flags and a sticky
// overflow flag; read data is the entry at the read pointer (show-ahead).
module sync_fifo
   import uart_tx_queue_pkg::*;
#(
   parameter int DEPTH  = TXQ_DEPTH_DEFAULT,
   parameter int ADDR_W = TXQ_ADDR_W_DEFAULT,
   parameter int WIDTH  = TXQ_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en,
   output logic [WIDTH-1:0]  rd_data,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;
   logic              overflow_q, overflow_d;
   logic              wr_ok, rd_ok;

   // A write while full is refused even if a pop frees a slot this cycle.
   assign wr_ok = wr_en & ~full_q;
   assign rd_ok = rd_en & ~empty_q;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | (wr_en & full_q);
      if (wr_ok) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + (ADDR_W+1)'(1);
         2'b01:   count_d = count_q - (ADDR_W+1)'(1);
         default: count_d = count_q;
      endcase
      full_d  = (count_d == (ADDR_W+1)'(DEPTH));
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (!reset && wr_ok) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data  = mem_q[rd_ptr_q];
   assign full     = full_q;
   assign empty    = empty_q;
   assign count    = count_q;
   assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue and launch controller in front of the UART transmitter: pops one
// byte, pulses tx_activate, then paces frames using the transmitter's tx_busy.
module uart_tx_queue
   import uart_tx_queue_pkg::*;
#(
   parameter int DEPTH       = TXQ_DEPTH_DEFAULT,
   parameter int ADDR_W      = TXQ_ADDR_W_DEFAULT,
   parameter int ACK_TIMEOUT = TXQ_ACK_TIMEOUT_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [7:0]        wr_data,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              ack_timeout,
   input  logic              tx_busy,
   output logic [7:0]        tx_data,
   output logic              tx_activate
);

   localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

   txq_state_e       state_q, state_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             tx_activate_q, tx_activate_d;
   logic [TMR_W-1:0] timer_q, timer_d, timer_inc;
   logic             ack_timeout_q, ack_timeout_d;
   logic             pop;
   logic [7:0]       fifo_rd_data;
   logic             fifo_empty;

   sync_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .WIDTH  (8)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .rd_en    (pop),
      .rd_data  (fifo_rd_data),
      .full     (full),
      .empty    (fifo_empty),
      .count    (count),
      .overflow (overflow)
   );

   assign timer_inc = timer_q + TMR_W'(1);

   always_comb begin
      state_d       = state_q;
      tx_data_d     = tx_data_q;
      timer_d       = timer_q;
      ack_timeout_d = ack_timeout_q;
      pop           = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               tx_data_d = fifo_rd_data;
               state_d   = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            timer_d = '0;
            state_d = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            // A byte that never gets acknowledged is dropped, not retried.
            if (tx_busy) begin
               state_d = ST_WAIT_DONE;
            end else if (timer_inc == TMR_W'(ACK_TIMEOUT)) begin
               ack_timeout_d = 1'b1;
               state_d       = ST_IDLE;
            end else begin
               timer_d = timer_inc;
            end
         end
         ST_WAIT_DONE: begin
            if (!tx_busy) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // Registered copy of (state == LAUNCH) so the pulse comes straight off a flop.
      tx_activate_d = (state_d == ST_LAUNCH);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         tx_data_q     <= 8'h00;
         tx_activate_q <= 1'b0;
         timer_q       <= '0;
         ack_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         tx_data_q     <= tx_data_d;
         tx_activate_q <= tx_activate_d;
         timer_q       <= timer_d;
         ack_timeout_q <= ack_timeout_d;
      end
   end

   assign empty       = fifo_empty;
   assign ack_timeout = ack_timeout_q;
   assign tx_data     = tx_data_q;
   assign tx_activate = tx_activate_q;

endmodule
